bcd_countdown_timer: RTL

- Multi-digit BCD down-counter (countdown timer).
- Counterpart to the team's up-counting decade counter: same slow-enable tick style, opposite direction.
- Loads a BCD preset and decrements once per qualified tick until it reaches 00.
- Then raises a one-cycle done pulse. Sits between the slow-tick source and display/control logic.

---
 rtl/bcd_timer_pkg.sv | 22 ++
 rtl/bcd_down_digit.sv | 27 ++
 rtl/bcd_countdown_timer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Used by bcd_down_digit and bcd_countdown_timer.
package bcd_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } timer_state_e;

  // A non-decimal nibble is treated as the largest legal digit.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD digit decrementer with a borrow chain.
// The zero flag reports the value this digit produces.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  bcd_digit_t i_digit,
  input  logic       i_borrow,
  output bcd_digit_t o_digit,
  output logic       o_borrow,
  output logic       o_zero
);

  always_comb begin
    o_digit  = i_digit;
    o_borrow = 1'b0;
    if (i_borrow) begin
      if (i_digit == BCD_ZERO) begin
        o_digit  = BCD_MAX;
        o_borrow = 1'b1;
      end else begin
        o_digit = i_digit - 4'd1;
      end
    end
    o_zero = (o_digit == BCD_ZERO);
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: load, start/pause/resume, one-cycle done pulse.
// Optional BCD_COUNTDOWN_AUTO_RELOAD_EN reloads the preset on reaching zero.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick_en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done
);

  localparam int unsigned CW = 4 * DIGITS;

  timer_state_e    r_state;
  timer_state_e    w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_reload;
  logic            r_running;
  logic            r_done;

  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_reload_nxt;
  logic            w_running_nxt;
  logic            w_done_nxt;

  logic [CW-1:0]   w_load_san;
  logic [CW-1:0]   w_dec;
  logic [DIGITS:0] w_borrow;
  logic [DIGITS-1:0] w_zero;
  logic            w_count_zero;
  logic            w_dec_zero;
  logic            w_reload_zero;
  logic            w_tick_run;

  always_comb begin
    w_load_san = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_load_san[4*i +: 4] = bcd_sanitize(load_val[4*i +: 4]);
    end
  end

  // Ripple-borrow decrement chain; the LSD always receives a borrow.
  assign w_borrow[0] = 1'b1;

  for (genvar gi = 0; gi < int'(DIGITS); gi++) begin : g_digit
    bcd_down_digit u_digit (
      .i_digit  (r_count[4*gi +: 4]),
      .i_borrow (w_borrow[gi]),
      .o_digit  (w_dec[4*gi +: 4]),
      .o_borrow (w_borrow[gi+1]),
      .o_zero   (w_zero[gi])
    );
  end

  assign w_count_zero  = (r_count == '0);
  assign w_reload_zero = (r_reload == '0);
  // A borrow out of the MSD means the count wrapped from zero, not that it reached zero.
  assign w_dec_zero    = (&w_zero) & ~w_borrow[DIGITS];
  assign w_tick_run    = ~pause & tick_en;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!pause && start) begin
            w_state_nxt = w_count_zero ? DONE : RUN;
          end
        end
        RUN: begin
          if (pause) begin
            w_state_nxt = HOLD;
          end else if (tick_en && w_dec_zero) begin
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            w_state_nxt = w_reload_zero ? DONE : RUN;
`else
            w_state_nxt = DONE;
`endif
          end
        end
        HOLD: begin
          if (!pause && start) begin
            w_state_nxt = RUN;
          end
        end
        DONE: w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (load) begin
      w_count_nxt  = w_load_san;
      w_reload_nxt = w_load_san;
    end else begin
      case (r_state)
        IDLE: begin
          if (!pause && start && w_count_zero) begin
            w_done_nxt = 1'b1;
          end
        end
        RUN: begin
          if (w_tick_run) begin
            w_count_nxt = w_dec;
            if (w_dec_zero) begin
              w_done_nxt = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
              if (!w_reload_zero) begin
                w_count_nxt = r_reload;
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
    w_running_nxt = (w_state_nxt == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_reload  <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

`ifndef BCD_COUNTDOWN_AUTO_RELOAD_EN
  // Reload register only feeds the auto-reload path; keep it observable for lint.
  logic w_reload_unused;
  assign w_reload_unused = w_reload_zero;
`endif

  assign count   = r_count;
  assign running = r_running;
  assign done    = r_done;

endmodule
